// File: rtl/operand_fetch_pkg.sv
// Shared sizing for the operand-fetch stage and its bypass helper.
package operand_fetch_pkg;

  // Default register-file geometry: 32 registers of 32 bits.
  localparam int OF_REG_ADDR_SIZE = 5;
  localparam int OF_REG_SIZE      = 32;

endpackage

// File: rtl/operand_fetch_wb_bypass.sv
// Writeback compare-and-select: returns the writeback data when it targets
// the given register, otherwise the supplied operand value.
module operand_fetch_wb_bypass #(
  parameter int REG_ADDR_SIZE = 5,
  parameter int REG_SIZE      = 32
) (
  input  logic [REG_ADDR_SIZE-1:0] addr,
  input  logic [REG_SIZE-1:0]      data,
  input  logic                     wb_we,
  input  logic [REG_ADDR_SIZE-1:0] wb_rd,
  input  logic [REG_SIZE-1:0]      wb_data,
  output logic [REG_SIZE-1:0]      result
);

  // Register 0 is treated like any other register.
  assign result = (wb_we && (wb_rd == addr)) ? wb_data : data;

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: issues registered reads to the register file,
// forwards writeback onto its write port, and returns operands that stay
// coherent with writebacks while the execute stage stalls.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int REG_ADDR_SIZE = OF_REG_ADDR_SIZE,
  parameter int REG_SIZE      = OF_REG_SIZE
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [REG_ADDR_SIZE-1:0] in_rs1,
  input  logic [REG_ADDR_SIZE-1:0] in_rs2,
  input  logic [REG_ADDR_SIZE-1:0] in_rd,
  input  logic                     wb_we,
  input  logic [REG_ADDR_SIZE-1:0] wb_rd,
  input  logic [REG_SIZE-1:0]      wb_data,
  output logic [REG_ADDR_SIZE-1:0] rf_rs1,
  output logic [REG_ADDR_SIZE-1:0] rf_rs2,
  output logic                     rf_we,
  output logic [REG_ADDR_SIZE-1:0] rf_rd,
  output logic [REG_SIZE-1:0]      rf_indata,
  input  logic [REG_SIZE-1:0]      rf_rv1,
  input  logic [REG_SIZE-1:0]      rf_rv2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [REG_SIZE-1:0]      out_op1,
  output logic [REG_SIZE-1:0]      out_op2,
  output logic [REG_ADDR_SIZE-1:0] out_rd
);

  // S1: read in flight
  logic                     s1_valid_q, s1_valid_d;
  logic [REG_ADDR_SIZE-1:0] s1_rs1_q, s1_rs1_d;
  logic [REG_ADDR_SIZE-1:0] s1_rs2_q, s1_rs2_d;
  logic [REG_ADDR_SIZE-1:0] s1_rd_q, s1_rd_d;

  // S2: output register
  logic                     out_valid_q, out_valid_d;
  logic [REG_SIZE-1:0]      out_op1_q, out_op1_d;
  logic [REG_SIZE-1:0]      out_op2_q, out_op2_d;
  logic [REG_ADDR_SIZE-1:0] out_rd_q, out_rd_d;
  logic [REG_ADDR_SIZE-1:0] s2_rs1_q, s2_rs1_d;
  logic [REG_ADDR_SIZE-1:0] s2_rs2_q, s2_rs2_d;

  logic s2_free, advance, accept;
  logic [REG_SIZE-1:0] load_op1, load_op2, hold_op1, hold_op2;

  assign s2_free  = !out_valid_q || out_ready;
  assign advance  = s1_valid_q && s2_free;
  assign in_ready = !s1_valid_q || s2_free;
  assign accept   = in_valid && in_ready;

  // A stalled S1 keeps re-reading its own registers so late writes land.
  assign rf_rs1 = accept ? in_rs1 : s1_rs1_q;
  assign rf_rs2 = accept ? in_rs2 : s1_rs2_q;

  // The writeback bus is the register file's only write path.
  assign rf_we     = wb_we;
  assign rf_rd     = wb_rd;
  assign rf_indata = wb_data;

  assign out_valid = out_valid_q;
  assign out_op1   = out_op1_q;
  assign out_op2   = out_op2_q;
  assign out_rd    = out_rd_q;

  // Load path: catch a write on the same edge the registered read completes.
  operand_fetch_wb_bypass #(.REG_ADDR_SIZE(REG_ADDR_SIZE), .REG_SIZE(REG_SIZE)) u_load1 (
    .addr(s1_rs1_q), .data(rf_rv1), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .result(load_op1));
  operand_fetch_wb_bypass #(.REG_ADDR_SIZE(REG_ADDR_SIZE), .REG_SIZE(REG_SIZE)) u_load2 (
    .addr(s1_rs2_q), .data(rf_rv2), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .result(load_op2));

  // Hold path: keep held operands coherent with later writebacks.
  operand_fetch_wb_bypass #(.REG_ADDR_SIZE(REG_ADDR_SIZE), .REG_SIZE(REG_SIZE)) u_hold1 (
    .addr(s2_rs1_q), .data(out_op1_q), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .result(hold_op1));
  operand_fetch_wb_bypass #(.REG_ADDR_SIZE(REG_ADDR_SIZE), .REG_SIZE(REG_SIZE)) u_hold2 (
    .addr(s2_rs2_q), .data(out_op2_q), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .result(hold_op2));

  // Next-state for both stages from the handshake.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_rs1_d    = s1_rs1_q;
    s1_rs2_d    = s1_rs2_q;
    s1_rd_d     = s1_rd_q;
    out_valid_d = out_valid_q;
    out_op1_d   = out_op1_q;
    out_op2_d   = out_op2_q;
    out_rd_d    = out_rd_q;
    s2_rs1_d    = s2_rs1_q;
    s2_rs2_d    = s2_rs2_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_rs1_d   = in_rs1;
      s1_rs2_d   = in_rs2;
      s1_rd_d    = in_rd;
    end else if (advance) begin
      s1_valid_d = 1'b0;
    end

    if (advance) begin
      out_valid_d = 1'b1;
      out_op1_d   = load_op1;
      out_op2_d   = load_op2;
      out_rd_d    = s1_rd_q;
      s2_rs1_d    = s1_rs1_q;
      s2_rs2_d    = s1_rs2_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else if (out_valid_q) begin
      out_op1_d = hold_op1;
      out_op2_d = hold_op2;
    end
  end

  // State registers; reset discards any in-flight request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_rs1_q    <= '0;
      s1_rs2_q    <= '0;
      s1_rd_q     <= '0;
      out_valid_q <= 1'b0;
      out_op1_q   <= '0;
      out_op2_q   <= '0;
      out_rd_q    <= '0;
      s2_rs1_q    <= '0;
      s2_rs2_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_rs1_q    <= s1_rs1_d;
      s1_rs2_q    <= s1_rs2_d;
      s1_rd_q     <= s1_rd_d;
      out_valid_q <= out_valid_d;
      out_op1_q   <= out_op1_d;
      out_op2_q   <= out_op2_d;
      out_rd_q    <= out_rd_d;
      s2_rs1_q    <= s2_rs1_d;
      s2_rs2_q    <= s2_rs2_d;
    end
  end

endmodule
